// File: rtl/ps2_kbd_tx_pkg.sv
// Shared types and helpers for the PS/2 keyboard-side transmitter.
package ps2_pkg;

    localparam int PS2_FRAME_BITS = 11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HIGH,
        LOW,
        HOLD,
        GAP
    } state_t;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_kbd_tx_if.sv
// Byte stream port: scan-code bytes offered on a valid/ready handshake.
interface ps2_kbd_tx_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/ps2_kbd_tx_fifo.sv
// Byte FIFO with occupancy count; a full FIFO refuses pushes even while popping.
module ps2_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [7:0]               wdata,
    input  logic                     pop,
    output logic [7:0]               rdata,
    output logic                     ready,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign ready   = (count != FULL);
    assign do_push = push && ready;
    assign do_pop  = pop && (count != '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/ps2_kbd_tx.sv
// PS/2 device-side transmitter: queues scan codes and shifts each out as an 11-bit frame.
// state | meaning
// IDLE  | pins high, waiting for a byte (or a pending retransmit) with inhibit low
// LOAD  | build frame register from FIFO head, or reuse it on retransmit
// HIGH  | ps2_clk high, current bit presented on ps2_data
// LOW   | ps2_clk low, receiver samples the bit on the falling edge
// HOLD  | frame aborted by host inhibit, waiting for release
// GAP   | mandatory idle-high spacing after a frame or an abort
module ps2_kbd_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HALF   = 16,
    parameter int GAP_CYCLES = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    ps2_kbd_tx_if.slave                   in_port,
    input  logic                          inhibit,
    output logic                          ps2_clk,
    output logic                          ps2_data,
    output logic                          busy,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int PHASE_MAX = (CLK_HALF > GAP_CYCLES) ? CLK_HALF : GAP_CYCLES;
    localparam int PW        = $clog2(PHASE_MAX);
    localparam logic [PW-1:0] HALF_LOAD = PW'(CLK_HALF - 1);
    localparam logic [PW-1:0] GAP_LOAD  = PW'(GAP_CYCLES - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(PS2_FRAME_BITS - 1);

    state_t                    state;
    logic [PW-1:0]             phase;
    logic [3:0]                bit_idx;
    logic [3:0]                bit_nxt;
    logic [PS2_FRAME_BITS-1:0] frame;
    logic [PS2_FRAME_BITS-1:0] frame_load;
    logic                      retx;
    logic                      abort;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic [7:0]                fifo_data;

    assign fifo_push  = in_port.in_valid && in_port.in_ready;
    assign fifo_pop   = (state == LOAD) && !retx;
    assign frame_load = retx ? frame : {1'b1, odd_parity(fifo_data), fifo_data, 1'b0};
    assign bit_nxt    = bit_idx + 4'd1;
    // Once the stop bit is being presented the host is too late to abort.
    assign abort      = inhibit && (bit_idx < LAST_BIT);
    assign busy       = (state != IDLE);

    ps2_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (in_port.in_data),
        .pop   (fifo_pop),
        .rdata (fifo_data),
        .ready (in_port.in_ready),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            phase      <= '0;
            bit_idx    <= '0;
            frame      <= '1;
            retx       <= 1'b0;
            ps2_clk    <= 1'b1;
            ps2_data   <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if ((retx || fifo_count != '0) && !inhibit) state <= LOAD;
                end
                LOAD: begin
                    frame    <= frame_load;
                    retx     <= 1'b0;
                    bit_idx  <= '0;
                    phase    <= HALF_LOAD;
                    ps2_clk  <= 1'b1;
                    ps2_data <= frame_load[0];
                    state    <= HIGH;
                end
                HIGH: begin
                    if (abort) begin
                        retx     <= 1'b1;
                        ps2_clk  <= 1'b1;
                        ps2_data <= 1'b1;
                        state    <= HOLD;
                    end else if (phase == '0) begin
                        ps2_clk <= 1'b0;
                        phase   <= HALF_LOAD;
                        state   <= LOW;
                    end else begin
                        phase <= phase - 1'b1;
                    end
                end
                LOW: begin
                    if (abort) begin
                        retx     <= 1'b1;
                        ps2_clk  <= 1'b1;
                        ps2_data <= 1'b1;
                        state    <= HOLD;
                    end else if (phase == '0) begin
                        ps2_clk <= 1'b1;
                        if (bit_idx == LAST_BIT) begin
                            ps2_data   <= 1'b1;
                            phase      <= GAP_LOAD;
                            frame_done <= 1'b1;
                            state      <= GAP;
                        end else begin
                            bit_idx  <= bit_nxt;
                            ps2_data <= frame[bit_nxt];
                            phase    <= HALF_LOAD;
                            state    <= HIGH;
                        end
                    end else begin
                        phase <= phase - 1'b1;
                    end
                end
                HOLD: begin
                    if (!inhibit) begin
                        phase <= GAP_LOAD;
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (phase == '0) state <= IDLE;
                    else             phase <= phase - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Bench for ps2_kbd_tx: directed frame vectors plus inhibit, back-pressure and reset sequences.
module tb_ps2_kbd_tx;
    localparam int CLK_HALF   = 4;
    localparam int GAP_CYCLES = 32;
    localparam int FIFO_DEPTH = 8;

    typedef struct {
        logic [7:0]  code;
        logic [10:0] frame;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       inhibit;
    logic       ps2_clk;
    logic       ps2_data;
    logic       busy;
    logic       frame_done;
    logic [3:0] fifo_count;

    ps2_kbd_tx_if kif ();

    ps2_kbd_tx #(
        .CLK_HALF   (CLK_HALF),
        .GAP_CYCLES (GAP_CYCLES),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_port    (kif.slave),
        .inhibit    (inhibit),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .busy       (busy),
        .frame_done (frame_done),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int push_edge = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int done_count = 0;
    int last_idle = 0;
    int hi_run = 0;
    int idle_run = 0;
    logic [3:0]  rx_cnt = '0;
    logic [10:0] rx_sh = '0;
    logic [10:0] rx_q[$];
    logic        prev_clk = 1'b1;
    logic        prev_data = 1'b1;
    vec_t        vecs[6];

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Receiver model: samples ps2_data on ps2_clk falling edges, like the APB receiver.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            rx_cnt = '0; hi_run = 0; idle_run = 0; prev_clk = 1'b1; prev_data = 1'b1;
        end else begin
            if (frame_done) begin done_count++; done_cyc = cyc; end
            if (prev_data && !ps2_data && ps2_clk && rx_cnt == 4'd0) begin
                start_cyc = cyc;
                last_idle = idle_run;
            end
            if (prev_clk && !ps2_clk) begin
                rx_sh[rx_cnt] = ps2_data;
                if (rx_cnt == 4'd10) begin rx_q.push_back(rx_sh); rx_cnt = '0; end
                else rx_cnt = rx_cnt + 4'd1;
            end
            hi_run = ps2_clk ? hi_run + 1 : 0;
            if (hi_run > 3 * CLK_HALF) rx_cnt = '0;
            idle_run = (ps2_clk && ps2_data) ? idle_run + 1 : 0;
            prev_clk = ps2_clk;
            prev_data = ps2_data;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting for DUT", name);
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    // Called at a falling clock edge; returns at the falling edge after acceptance.
    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        kif.in_valid = 1'b1;
        kif.in_data  = b;
        while (!kif.in_ready && n < 2000) begin @(negedge clk); n++; end
        if (!kif.in_ready) tmo("push");
        push_edge = cyc + 1;
        @(negedge clk);
        kif.in_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input string name);
        int k = 0;
        while (rx_q.size() < n && k < 400 * n + 400) begin @(negedge clk); k++; end
        if (rx_q.size() < n) tmo(name);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 5000) begin @(negedge clk); k++; end
        if (busy) tmo(name);
    endtask

    task automatic check_frame(input string name, input logic [10:0] exp);
        logic [10:0] fr;
        if (rx_q.size() == 0) tmo(name);
        else begin
            fr = rx_q.pop_front();
            chk(name, int'(fr), int'(exp));
        end
    endtask

    task automatic count_falls(input int n, input string name);
        int   falls = 0;
        int   k = 0;
        logic pc = ps2_clk;
        while (falls < n && k < 1000) begin
            @(posedge clk); #1;
            if (pc && !ps2_clk) falls++;
            pc = ps2_clk;
            k++;
        end
        if (falls < n) tmo(name);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int k;
        int k0;
        int acc;
        rst_n = 1'b0;
        inhibit = 1'b0;
        kif.in_valid = 1'b0;
        kif.in_data = '0;
        vecs[0] = '{8'h1C, {1'b1, 1'b0, 8'h1C, 1'b0}};
        vecs[1] = '{8'hF0, {1'b1, 1'b1, 8'hF0, 1'b0}};
        vecs[2] = '{8'h5A, {1'b1, 1'b1, 8'h5A, 1'b0}};
        vecs[3] = '{8'h00, {1'b1, 1'b1, 8'h00, 1'b0}};
        vecs[4] = '{8'hFF, {1'b1, 1'b1, 8'hFF, 1'b0}};
        vecs[5] = '{8'h80, {1'b1, 1'b0, 8'h80, 1'b0}};

        repeat (3) @(negedge clk);
        chk("rst_ps2_clk", int'(ps2_clk), 1);
        chk("rst_ps2_data", int'(ps2_data), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_fifo_count", int'(fifo_count), 0);
        chk("rst_in_ready", int'(kif.in_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            wait_idle("tbl_idle");
            d0 = done_count;
            push_byte(vecs[i].code);
            wait_frames(1, "tbl_wait");
            wait_idle("tbl_idle2");
            check_frame("tbl_frame", vecs[i].frame);
            chk("tbl_latency", start_cyc - push_edge, 2);
            chk("tbl_frame_len", done_cyc - start_cyc, 22 * CLK_HALF);
            chk("tbl_done_cnt", done_count - d0, 1);
        end

        // Two queued bytes: order and inter-frame idle spacing.
        wait_idle("t3_idle");
        d0 = done_count;
        push_byte(8'hF0);
        push_byte(8'h1C);
        wait_frames(2, "t3_wait");
        wait_idle("t3_idle2");
        check_frame("t3_first", {1'b1, 1'b1, 8'hF0, 1'b0});
        check_frame("t3_second", {1'b1, 1'b0, 8'h1C, 1'b0});
        chk("t3_gap", int'(last_idle >= GAP_CYCLES), 1);
        chk("t3_done_cnt", done_count - d0, 2);

        // Fill the FIFO under inhibit; ninth byte waits for the first pop.
        wait_idle("t4_idle");
        inhibit = 1'b1;
        d0 = done_count;
        for (int i = 0; i < 8; i++) begin
            chk("t4_ready", int'(kif.in_ready), 1);
            push_byte(8'h20 + 8'(i));
        end
        chk("t4_count_full", int'(fifo_count), 8);
        chk("t4_ready_full", int'(kif.in_ready), 0);
        kif.in_valid = 1'b1;
        kif.in_data = 8'h28;
        repeat (4) @(negedge clk);
        chk("t4_stall", int'(kif.in_ready), 0);
        chk("t4_busy_inhibit", int'(busy), 0);
        k0 = cyc;
        inhibit = 1'b0;
        k = 0;
        while (!kif.in_ready && k < 100) begin @(negedge clk); k++; end
        if (!kif.in_ready) tmo("t4_ready_wait");
        acc = cyc + 1;
        @(negedge clk);
        kif.in_valid = 1'b0;
        chk("t4_accept_edge", acc - k0, 3);
        chk("t4_count_after", int'(fifo_count), 8);
        wait_frames(9, "t4_wait");
        wait_idle("t4_idle2");
        for (int i = 0; i < 9; i++) check_frame("t4_frame", mk_frame(8'h20 + 8'(i)));
        chk("t4_done_cnt", done_count - d0, 9);

        // Abort during bit 4 low phase, then retransmit from the saved frame.
        wait_idle("t5_idle");
        d0 = done_count;
        push_byte(8'h5A);
        count_falls(5, "t5_falls");
        inhibit = 1'b1;
        @(posedge clk); #1;
        chk("t5_abort_clk", int'(ps2_clk), 1);
        chk("t5_abort_data", int'(ps2_data), 1);
        chk("t5_hold_busy", int'(busy), 1);
        repeat (20) @(negedge clk);
        push_byte(8'h29);
        chk("t5_fifo_hold", int'(fifo_count), 1);
        chk("t5_no_done", done_count - d0, 0);
        inhibit = 1'b0;
        wait_frames(1, "t5_wait");
        chk("t5_fifo_retx", int'(fifo_count), 1);
        check_frame("t5_retx_frame", {1'b1, 1'b1, 8'h5A, 1'b0});
        wait_frames(1, "t5_wait2");
        wait_idle("t5_idle2");
        check_frame("t5_next_frame", {1'b1, 1'b0, 8'h29, 1'b0});
        chk("t5_done_cnt", done_count - d0, 2);

        // Inhibit while the stop bit is presented: frame completes, next byte parked.
        wait_idle("t6_idle");
        d0 = done_count;
        push_byte(8'h12);
        push_byte(8'h34);
        count_falls(10, "t6_falls");
        k = 0;
        while (!ps2_clk && k < 100) begin @(posedge clk); #1; k++; end
        if (!ps2_clk) tmo("t6_rise");
        inhibit = 1'b1;
        wait_frames(1, "t6_wait");
        repeat (60) @(negedge clk);
        check_frame("t6_frame", {1'b1, 1'b1, 8'h12, 1'b0});
        chk("t6_done_cnt", done_count - d0, 1);
        chk("t6_busy", int'(busy), 0);
        chk("t6_fifo_parked", int'(fifo_count), 1);
        chk("t6_pins", int'({ps2_clk, ps2_data}), 3);
        inhibit = 1'b0;
        wait_frames(1, "t6_wait2");
        wait_idle("t6_idle2");
        check_frame("t6_next", {1'b1, 1'b0, 8'h34, 1'b0});

        // Reset mid-frame while the clock pin is low.
        wait_idle("t1_idle");
        push_byte(8'h1C);
        push_byte(8'h5A);
        k = 0;
        while (ps2_clk && k < 200) begin @(negedge clk); k++; end
        if (ps2_clk) tmo("t1_low");
        chk("t1_pre_count", int'(fifo_count), 1);
        rst_n = 1'b0;
        #1;
        chk("t1_ps2_clk", int'(ps2_clk), 1);
        chk("t1_ps2_data", int'(ps2_data), 1);
        chk("t1_busy", int'(busy), 0);
        chk("t1_fifo_count", int'(fifo_count), 0);
        chk("t1_frame_done", int'(frame_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1_in_ready", int'(kif.in_ready), 1);
        rx_q.delete();
        push_byte(8'h1C);
        wait_frames(1, "t1_wait");
        wait_idle("t1_idle2");
        check_frame("t1_after_reset", {1'b1, 1'b0, 8'h1C, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
